pipelined_nbit_adder: RTL and testbench



---
 rtl/pipelined_nbit_adder.sv | 109 ++++++++++
 tb/tb_pipelined_nbit_adder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_nbit_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipelined_nbit_adder
//  Brief    : WIDTH-bit add/subtract split into SEG_W-bit ripple segments,
//             one segment per pipeline stage, with valid/ready and global stall.
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_nbit_adder #(
   parameter int WIDTH = 20,
   parameter int SEG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int c_STAGES = WIDTH / SEG_W;
   localparam int c_LAST   = c_STAGES - 1;

   generate
      if ((WIDTH % SEG_W) != 0 || WIDTH < SEG_W || SEG_W < 1) begin : g_param_check
         $error("pipelined_nbit_adder: WIDTH must be a positive multiple of SEG_W");
      end
   endgenerate

   // Per-stage registers: operands carry B' (already inverted for subtract),
   // r_sum accumulates the finished low segments.
   logic             r_valid [c_STAGES];
   logic [WIDTH-1:0] r_a     [c_STAGES];
   logic [WIDTH-1:0] r_b     [c_STAGES];
   logic [WIDTH-1:0] r_sum   [c_STAGES];
   logic             r_carry [c_STAGES];

   // Stage inputs and combinational segment results
   logic             w_in_valid [c_STAGES];
   logic [WIDTH-1:0] w_in_a     [c_STAGES];
   logic [WIDTH-1:0] w_in_b     [c_STAGES];
   logic [WIDTH-1:0] w_in_sum   [c_STAGES];
   logic             w_in_cin   [c_STAGES];
   logic [SEG_W:0]   w_seg      [c_STAGES];
   logic [WIDTH-1:0] w_nxt_sum  [c_STAGES];
   logic             w_advance;

   assign w_advance = !r_valid[c_LAST] || out_ready;
   assign in_ready  = w_advance;

   always_comb begin
      w_in_valid[0] = in_valid;
      w_in_a[0]     = a;
      w_in_b[0]     = b ^ {WIDTH{sub}};
      w_in_sum[0]   = '0;
      w_in_cin[0]   = sub;
      for (int k = 1; k < c_STAGES; k++) begin
         w_in_valid[k] = r_valid[k-1];
         w_in_a[k]     = r_a[k-1];
         w_in_b[k]     = r_b[k-1];
         w_in_sum[k]   = r_sum[k-1];
         w_in_cin[k]   = r_carry[k-1];
      end
      for (int k = 0; k < c_STAGES; k++) begin
         w_seg[k] = {1'b0, w_in_a[k][k*SEG_W +: SEG_W]}
                  + {1'b0, w_in_b[k][k*SEG_W +: SEG_W]}
                  + {{SEG_W{1'b0}}, w_in_cin[k]};
         w_nxt_sum[k] = w_in_sum[k];
         w_nxt_sum[k][k*SEG_W +: SEG_W] = w_seg[k][SEG_W-1:0];
      end
   end

   // Data only loads behind a valid token, so bubbles leave the last result visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < c_STAGES; k++) begin
            r_valid[k] <= 1'b0;
            r_a[k]     <= '0;
            r_b[k]     <= '0;
            r_sum[k]   <= '0;
            r_carry[k] <= 1'b0;
         end
      end else if (w_advance) begin
         for (int k = 0; k < c_STAGES; k++) begin
            r_valid[k] <= w_in_valid[k];
            if (w_in_valid[k]) begin
               r_a[k]     <= w_in_a[k];
               r_b[k]     <= w_in_b[k];
               r_sum[k]   <= w_nxt_sum[k];
               r_carry[k] <= w_seg[k][SEG_W];
            end
         end
      end
   end

   assign out_valid = r_valid[c_LAST];
   assign sum       = r_sum[c_LAST];
   assign carry_out = r_carry[c_LAST];
   assign overflow  = (r_a[c_LAST][WIDTH-1] == r_b[c_LAST][WIDTH-1])
                   && (r_sum[c_LAST][WIDTH-1] != r_a[c_LAST][WIDTH-1]);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_nbit_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_nbit_adder
//  Brief    : Scoreboard bench for pipelined_nbit_adder (WIDTH=20, SEG_W=5).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_nbit_adder;

   localparam int WIDTH  = 20;
   localparam int SEG_W  = 5;
   localparam int STAGES = WIDTH / SEG_W;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             c;
      logic             o;
      int               cyc;
      bit               lat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             sub = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   bit   chk_lat = 1'b1;
   exp_t cur_exp;
   exp_t mon_e;
   exp_t sb[$];

   pipelined_nbit_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic s);
      exp_t             e;
      logic [WIDTH-1:0] yp;
      logic [WIDTH:0]   f;
      yp = s ? ~y : y;
      f  = {1'b0, x} + {1'b0, yp} + {{WIDTH{1'b0}}, s};
      e.s = f[WIDTH-1:0];
      e.c = f[WIDTH];
      e.o = (x[WIDTH-1] == yp[WIDTH-1]) && (f[WIDTH-1] != x[WIDTH-1]);
      e.cyc = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o);
      exp_t e;
      e.s = s; e.c = c; e.o = o; e.cyc = 0; e.lat = 1'b0;
      return e;
   endfunction

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic drive(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic ts, input exp_t e);
      bit done = 1'b0;
      cur_exp  = e;
      a = ta; b = tb_; sub = ts; in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      if (!done) check("drive_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
      check(tag, sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: push on accepted input, compare front on every valid output.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
               mon_e = sb[0];
               check("sum", {12'd0, sum}, {12'd0, mon_e.s});
               check("carry_out", {31'd0, carry_out}, {31'd0, mon_e.c});
               check("overflow", {31'd0, overflow}, {31'd0, mon_e.o});
               if (out_ready) begin
                  if (mon_e.lat) check("latency", cyc - mon_e.cyc, STAGES);
                  void'(sb.pop_front());
               end
            end
         end
         if (in_valid && in_ready) begin
            mon_e     = cur_exp;
            mon_e.cyc = cyc;
            mon_e.lat = chk_lat;
            sb.push_back(mon_e);
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic             rs;
      exp_t             ex;
      bit               seen;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum", {12'd0, sum}, 32'd0);
      check("rst_carry", {31'd0, carry_out}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // Directed corner cases with hand-derived results
      drive(20'hFFFFF, 20'h00001, 1'b0, mk(20'h00000, 1'b1, 1'b0));
      drive(20'h00005, 20'h00007, 1'b1, mk(20'hFFFFE, 1'b0, 1'b0));
      drive(20'h00007, 20'h00005, 1'b1, mk(20'h00002, 1'b1, 1'b0));
      drive(20'h7FFFF, 20'h00001, 1'b0, mk(20'h80000, 1'b0, 1'b1));
      drive(20'h0001F, 20'h00001, 1'b0, mk(20'h00020, 1'b0, 1'b0));
      drive(20'h80000, 20'h00001, 1'b1, mk(20'h7FFFF, 1'b1, 1'b1));
      drain("drain_directed");

      // Back-to-back random mixed add/sub stream
      for (int i = 0; i < 8; i++) begin
         ra = WIDTH'($urandom); rb = WIDTH'($urandom); rs = 1'($urandom);
         drive(ra, rb, rs, model(ra, rb, rs));
      end
      drain("drain_stream");

      // Fill the pipe with the consumer stalled, then hold for 3 cycles
      chk_lat   = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
         ra = WIDTH'($urandom); rb = WIDTH'($urandom); rs = 1'($urandom);
         drive(ra, rb, rs, model(ra, rb, rs));
      end
      ra = WIDTH'($urandom); rb = WIDTH'($urandom);
      cur_exp = model(ra, rb, 1'b0);
      a = ra; b = rb; sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("stall_out_valid", {31'd0, out_valid}, 32'd1);
         check("stall_sb_depth", sb.size(), STAGES);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drive(ra, rb, 1'b0, model(ra, rb, 1'b0));
      drain("drain_stall");
      chk_lat = 1'b1;

      // Bubble: 1,0,1 in gives 1,0,1 out with sum held through the gap
      ex = model(20'h12345, 20'h11111, 1'b0);
      drive(20'h12345, 20'h11111, 1'b0, ex);
      idle(1);
      drive(20'h7FFFF, 20'h00001, 1'b0, mk(20'h80000, 1'b0, 1'b1));
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      check("bubble_first_valid", {31'd0, seen}, 32'd1);
      @(negedge clk);
      check("bubble_gap_valid", {31'd0, out_valid}, 32'd0);
      check("bubble_gap_sum", {12'd0, sum}, {12'd0, ex.s});
      @(negedge clk);
      check("bubble_second_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
      drain("drain_bubble");

      // Reset with three operations in flight: none may emerge
      drive(20'h00011, 20'h00022, 1'b0, model(20'h00011, 20'h00022, 1'b0));
      drive(20'h7FFFF, 20'h7FFFF, 1'b0, model(20'h7FFFF, 20'h7FFFF, 1'b0));
      drive(20'hFFFFF, 20'h00001, 1'b0, model(20'hFFFFF, 20'h00001, 1'b0));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_sum", {12'd0, sum}, 32'd0);
      check("mid_rst_carry", {31'd0, carry_out}, 32'd0);
      check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
      @(posedge clk);
      #1;
      drive(20'h0ABCD, 20'h01234, 1'b1, model(20'h0ABCD, 20'h01234, 1'b1));
      drain("drain_after_rst");
      repeat (6) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
